// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM -> WB pipeline register for the five-stage RISC-V core.
// Holds the W-stage copy of the M-stage results, with stall (En=0) and
// bubble (Flush=1) control, a valid bit, load-data formatting with
// misalignment detection, and a retired-instruction counter.
//
// Stage control: there is no valid/ready handshake here. The pipeline
// controller owns En and Flush. An edge with Flush=1 captures a bubble.
// An edge with Flush=0 and En=0 holds every register. An edge with
// Flush=1 and En=0 still captures the bubble. Any other edge captures
// the M-stage slot. Asynchronous reset overrides all of these.
//
// Every output is a direct register output. The formatting and
// misalignment logic sits on the D side, in the M-stage cycle.
module mem_wb_pipe #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int RSRC_W = 2,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              En,
   input  logic              Flush,
   input  logic              ValidM,
   input  logic [XLEN-1:0]   ALUResultM,
   input  logic [XLEN-1:0]   WriteDataM,
   input  logic [XLEN-1:0]   ReadDataM,
   input  logic [REG_AW-1:0] RdM,
   input  logic [XLEN-1:0]   PCPlus4M,
   input  logic              RegWriteM,
   input  logic [RSRC_W-1:0] ResultSrcM,
   input  logic              MemReadM,
   input  logic [2:0]        LoadTypeM,
   output logic [XLEN-1:0]   ALUResultW,
   output logic [XLEN-1:0]   PCPlus4W,
   output logic [XLEN-1:0]   ReadDataW,
   output logic [REG_AW-1:0] RdW,
   output logic              RegWriteW,
   output logic [RSRC_W-1:0] ResultSrcW,
   output logic              ValidW,
   output logic              LoadMisalignW,
   output logic [CNT_W-1:0]  InstRetW
);

   // funct3 encodings of the loads (any other code is treated as LW)
   localparam logic [2:0] LT_LB  = 3'b000;
   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LW  = 3'b010;
   localparam logic [2:0] LT_LBU = 3'b100;
   localparam logic [2:0] LT_LHU = 3'b101;

   // Store data is not needed after MEM; the port exists only so the
   // stage drops into the existing core wiring unchanged.
   logic unused_wdata;
   assign unused_wdata = ^WriteDataM;

   logic [1:0]      off;         // byte offset within the loaded word
   logic [31:0]     word;        // low 32 bits of the raw memory word
   logic [7:0]      ld_byte;     // byte selected by the offset
   logic [15:0]     ld_half;     // halfword selected by off[1]
   logic [XLEN-1:0] ld_data;     // formatted load value, assuming aligned
   logic            ld_mis;      // offset illegal for this load width
   logic            d_mis;       // misalignment qualified by MemReadM
   logic [XLEN-1:0] d_readdata;  // D input of ReadDataW
   logic            d_regwrite;  // D input of RegWriteW
   logic            capture;     // this edge loads the M-stage slot
   logic            retire;      // this edge retires a valid instruction

   // Pick the addressed byte and halfword out of the raw word
   always_comb begin
      off     = ALUResultM[1:0];
      word    = ReadDataM[31:0];
      ld_byte = word[{off, 3'b000} +: 8];
      ld_half = word[{off[1], 4'b0000} +: 16];
   end

   // Extend the selected field to XLEN and flag offsets illegal for its width
   always_comb begin
      ld_data = '0;
      ld_mis  = 1'b0;
      case (LoadTypeM)
         LT_LB: begin
            ld_data = XLEN'($signed(ld_byte));
         end
         LT_LBU: begin
            ld_data = XLEN'(ld_byte);
         end
         LT_LH: begin
            ld_data = XLEN'($signed(ld_half));
            ld_mis  = off[0];
         end
         LT_LHU: begin
            ld_data = XLEN'(ld_half);
            ld_mis  = off[0];
         end
         LT_LW: begin
            ld_data = XLEN'($signed(word));
            ld_mis  = |off;
         end
         default: begin
            // unknown widths behave like LW
            ld_data = XLEN'($signed(word));
            ld_mis  = |off;
         end
      endcase
   end

   // Build the write-back values; a misaligned load writes nothing and reads as 0
   always_comb begin
      d_mis      = MemReadM & ld_mis;
      d_readdata = ReadDataM;
      if (MemReadM) begin
         d_readdata = d_mis ? '0 : ld_data;
      end
      // an invalid slot or a trapping load must never reach the register file
      d_regwrite = RegWriteM & ValidM & ~d_mis;
   end

   assign capture = En & ~Flush;
   assign retire  = capture & ValidM;

   // W-stage registers: reset > flush (bubble) > stall (hold) > capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ALUResultW    <= '0;
         PCPlus4W      <= '0;
         ReadDataW     <= '0;
         RdW           <= '0;
         RegWriteW     <= 1'b0;
         ResultSrcW    <= '0;
         ValidW        <= 1'b0;
         LoadMisalignW <= 1'b0;
      end else if (Flush) begin
         ALUResultW    <= '0;
         PCPlus4W      <= '0;
         ReadDataW     <= '0;
         RdW           <= '0;
         RegWriteW     <= 1'b0;
         ResultSrcW    <= '0;
         ValidW        <= 1'b0;
         LoadMisalignW <= 1'b0;
      end else if (capture) begin
         ALUResultW    <= ALUResultM;
         PCPlus4W      <= PCPlus4M;
         ReadDataW     <= d_readdata;
         RdW           <= RdM;          // kept even for invalid slots, for debug
         RegWriteW     <= d_regwrite;
         ResultSrcW    <= ResultSrcM;
         ValidW        <= ValidM;
         LoadMisalignW <= d_mis;
      end
   end

   // Retired-instruction counter: counts valid captures, including
   // misaligned loads that retire into a trap, and wraps naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         InstRetW <= '0;
      end else if (retire) begin
         InstRetW <= InstRetW + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe. It drives directed vectors and keeps a
// behavioural model of the W stage. The model describes the stage in terms
// of load size, shift and mask, not in terms of the RTL structure. A second
// instance with CNT_W=4 shares the same inputs and exercises counter wrap.
module tb_mem_wb_pipe;

   localparam int XLEN = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT inputs ----------------
   logic              En, Flush, ValidM, RegWriteM, MemReadM;
   logic [XLEN-1:0]   ALUResultM, WriteDataM, ReadDataM, PCPlus4M;
   logic [4:0]        RdM;
   logic [1:0]        ResultSrcM;
   logic [2:0]        LoadTypeM;

   // ---------------- DUT outputs (default instance) ----------------
   logic [XLEN-1:0]   ALUResultW, PCPlus4W, ReadDataW;
   logic [4:0]        RdW;
   logic              RegWriteW, ValidW, LoadMisalignW;
   logic [1:0]        ResultSrcW;
   logic [31:0]       InstRetW;

   // ---------------- DUT outputs (CNT_W=4 instance) ----------------
   logic [XLEN-1:0]   alu4, pc4, rdata4;
   logic [4:0]        rd4;
   logic              rw4, valid4, mis4;
   logic [1:0]        rsrc4;
   logic [3:0]        cnt4;

   mem_wb_pipe dut (
      .clk(clk), .rst(rst), .En(En), .Flush(Flush), .ValidM(ValidM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
      .RdM(RdM), .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM),
      .ResultSrcM(ResultSrcM), .MemReadM(MemReadM), .LoadTypeM(LoadTypeM),
      .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .ReadDataW(ReadDataW),
      .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .ValidW(ValidW), .LoadMisalignW(LoadMisalignW), .InstRetW(InstRetW)
   );

   mem_wb_pipe #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .En(En), .Flush(Flush), .ValidM(ValidM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
      .RdM(RdM), .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM),
      .ResultSrcM(ResultSrcM), .MemReadM(MemReadM), .LoadTypeM(LoadTypeM),
      .ALUResultW(alu4), .PCPlus4W(pc4), .ReadDataW(rdata4),
      .RdW(rd4), .RegWriteW(rw4), .ResultSrcW(rsrc4),
      .ValidW(valid4), .LoadMisalignW(mis4), .InstRetW(cnt4)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] exp_alu, exp_pc, exp_rdata, exp_cnt;
   logic [4:0]  exp_rd;
   logic [1:0]  exp_rsrc;
   logic        exp_rw, exp_valid, exp_mis;

   // Returns {misaligned, formatted data} for one M-stage slot
   function automatic logic [32:0] load_model(input logic mr, input logic [2:0] lt,
                                              input logic [31:0] addr, input logic [31:0] raw);
      int          size;
      bit          uns;
      int          off;
      logic [31:0] mask, val;
      off = int'(addr[1:0]);
      case (lt)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         default:        size = 4;
      endcase
      uns = (lt == 3'b100) || (lt == 3'b101);
      if (!mr) return {1'b0, raw};
      if ((off % size) != 0) return {1'b1, 32'h0};
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      val  = (raw >> (8 * off)) & mask;
      if (!uns && size < 4 && val[8 * size - 1]) val = val | ~mask;
      return {1'b0, val};
   endfunction

   task automatic model_bubble();
      exp_alu = '0; exp_pc = '0; exp_rdata = '0; exp_rd = '0;
      exp_rsrc = '0; exp_rw = 1'b0; exp_valid = 1'b0; exp_mis = 1'b0;
   endtask

   task automatic model_reset();
      model_bubble();
      exp_cnt = '0;
   endtask

   // What one rising edge does to the W stage, given the current inputs
   task automatic model_capture();
      logic [32:0] r;
      if (!rst) begin
         model_reset();
      end else if (Flush) begin
         model_bubble();
      end else if (En) begin
         r         = load_model(MemReadM, LoadTypeM, ALUResultM, ReadDataM);
         exp_alu   = ALUResultM;
         exp_pc    = PCPlus4M;
         exp_rd    = RdM;
         exp_rsrc  = ResultSrcM;
         exp_valid = ValidM;
         exp_mis   = r[32];
         exp_rdata = r[31:0];
         exp_rw    = RegWriteM && ValidM && !r[32];
         if (ValidM) exp_cnt = exp_cnt + 32'd1;
      end
   endtask

   // Compare every output of both instances against the model
   task automatic compare_all();
      chk("ALUResultW",    ALUResultW,    exp_alu);
      chk("PCPlus4W",      PCPlus4W,      exp_pc);
      chk("ReadDataW",     ReadDataW,     exp_rdata);
      chk("RdW",           RdW,           exp_rd);
      chk("RegWriteW",     RegWriteW,     exp_rw);
      chk("ResultSrcW",    ResultSrcW,    exp_rsrc);
      chk("ValidW",        ValidW,        exp_valid);
      chk("LoadMisalignW", LoadMisalignW, exp_mis);
      chk("InstRetW",      InstRetW,      exp_cnt);
      chk("w4.ALUResultW", alu4,          exp_alu);
      chk("w4.ReadDataW",  rdata4,        exp_rdata);
      chk("w4.RdW",        rd4,           exp_rd);
      chk("w4.RegWriteW",  rw4,           exp_rw);
      chk("w4.ValidW",     valid4,        exp_valid);
      chk("w4.MisalignW",  mis4,          exp_mis);
      chk("w4.PCPlus4W",   pc4,           exp_pc);
      chk("w4.ResultSrcW", rsrc4,         exp_rsrc);
      chk("w4.InstRetW",   cnt4,          exp_cnt[3:0]);
   endtask

   // One clock: model follows the rising edge, outputs checked on the falling edge
   task automatic tick();
      @(posedge clk);
      model_capture();
      @(negedge clk);
      compare_all();
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic v, input logic rw, input logic [4:0] rd,
                         input logic mr, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] raw,
                         input logic [1:0] rsrc);
      En = 1'b1; Flush = 1'b0;
      ValidM = v; RegWriteM = rw; RdM = rd; MemReadM = mr; LoadTypeM = lt;
      ALUResultM = alu; ReadDataM = raw; ResultSrcM = rsrc;
      PCPlus4M = alu + 32'h104;
      WriteDataM = ~raw;
   endtask

   task automatic randomize_in();
      ValidM = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      MemReadM = 1'($urandom_range(0, 1)); LoadTypeM = 3'($urandom_range(0, 7));
      RdM = 5'($urandom_range(0, 31)); ResultSrcM = 2'($urandom_range(0, 3));
      ALUResultM = $urandom; ReadDataM = $urandom; PCPlus4M = $urandom;
      WriteDataM = $urandom; En = 1'($urandom_range(0, 1)); Flush = 1'($urandom_range(0, 1));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ALUResultW"}, ALUResultW, 32'h0);
      chk({tag, ".ReadDataW"},  ReadDataW,  32'h0);
      chk({tag, ".PCPlus4W"},   PCPlus4W,   32'h0);
      chk({tag, ".RdW"},        RdW,        5'h0);
      chk({tag, ".RegWriteW"},  RegWriteW,  1'b0);
      chk({tag, ".ValidW"},     ValidW,     1'b0);
      chk({tag, ".InstRetW"},   InstRetW,   32'h0);
      chk({tag, ".w4.InstRetW"}, cnt4,      4'h0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      // reset held from time 0 with inputs toggling; checked before the first edge
      randomize_in();
      #1;
      chk_all_zero("rst_t1");
      randomize_in();
      #2;
      chk_all_zero("rst_t3");
      model_reset();
      tick();
      randomize_in();
      tick();

      // first capture after release
      rst = 1'b1;
      set_in(1, 1, 5'd5, 0, 3'b010, 32'h1000, 32'h1234_5678, 2'b01);
      tick();
      chk("first.RdW", RdW, 5'd5);
      chk("first.RegWriteW", RegWriteW, 1'b1);
      chk("first.InstRetW", InstRetW, 32'd1);
      chk("first.ReadDataW", ReadDataW, 32'h1234_5678);

      // LB / LBU
      set_in(1, 1, 5'd7, 1, 3'b000, 32'h2003, 32'h80FF_7F01, 2'b01);
      tick();
      chk("lb_off3", ReadDataW, 32'hFFFF_FF80);
      set_in(1, 1, 5'd7, 1, 3'b100, 32'h2003, 32'h80FF_7F01, 2'b01);
      tick();
      chk("lbu_off3", ReadDataW, 32'h0000_0080);
      set_in(1, 1, 5'd7, 1, 3'b000, 32'h2001, 32'h80FF_7F01, 2'b01);
      tick();
      chk("lb_off1", ReadDataW, 32'h0000_007F);
      chk("lb_off1.mis", LoadMisalignW, 1'b0);

      // LH / LHU and halfword misalignment
      set_in(1, 1, 5'd8, 1, 3'b001, 32'h3002, 32'h8001_FFFE, 2'b01);
      tick();
      chk("lh_off2", ReadDataW, 32'hFFFF_8001);
      set_in(1, 1, 5'd8, 1, 3'b101, 32'h3000, 32'h8001_FFFE, 2'b01);
      tick();
      chk("lhu_off0", ReadDataW, 32'h0000_FFFE);
      set_in(1, 1, 5'd8, 1, 3'b001, 32'h3001, 32'h8001_FFFE, 2'b01);
      tick();
      chk("lh_off1.mis", LoadMisalignW, 1'b1);
      chk("lh_off1.rw", RegWriteW, 1'b0);
      chk("lh_off1.data", ReadDataW, 32'h0);
      chk("lh_off1.ret", InstRetW, 32'd7);

      // LW misalignment, then an odd code that behaves as LW
      set_in(1, 1, 5'd9, 1, 3'b010, 32'h4002, 32'hDEAD_BEEF, 2'b01);
      tick();
      chk("lw_off2.mis", LoadMisalignW, 1'b1);
      chk("lw_off2.rw", RegWriteW, 1'b0);
      set_in(1, 1, 5'd9, 1, 3'b111, 32'h4000, 32'hDEAD_BEEF, 2'b01);
      tick();
      chk("code7_off0", ReadDataW, 32'hDEAD_BEEF);
      chk("code7_off0.rw", RegWriteW, 1'b1);

      // non-load with a "misaligned" address passes raw data through
      set_in(1, 1, 5'd3, 0, 3'b001, 32'h5001, 32'hCAFE_F00D, 2'b00);
      tick();
      chk("noload.data", ReadDataW, 32'hCAFE_F00D);
      chk("noload.mis", LoadMisalignW, 1'b0);

      // asynchronous reset mid-run: outputs clear before any edge
      #1 rst = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      model_reset();
      randomize_in();
      tick();
      rst = 1'b1;

      // stream of three, then a two-cycle stall with changing inputs
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 5'(10 + i), 0, 3'b010, 32'h100 * (i + 1), 32'h11 * (i + 1), 2'b10);
         tick();
      end
      set_in(1, 1, 5'd20, 1, 3'b000, 32'h9999, 32'hFFFF_FFFF, 2'b11);
      En = 1'b0;
      tick();
      tick();
      chk("stall.ret", InstRetW, 32'd3);
      chk("stall.rd", RdW, 5'd12);
      chk("stall.alu", ALUResultW, 32'h300);

      // flush during stall: bubble held for every cycle, counter kept
      Flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush.valid", ValidW, 1'b0);
         chk("flush.rw", RegWriteW, 1'b0);
         chk("flush.ret", InstRetW, 32'd3);
      end

      // release: next valid capture retires the fourth instruction
      set_in(1, 1, 5'd13, 0, 3'b010, 32'h400, 32'h44, 2'b10);
      tick();
      chk("release.ret", InstRetW, 32'd4);
      chk("release.rd", RdW, 5'd13);

      // invalid slot requesting a write
      set_in(0, 1, 5'd14, 0, 3'b010, 32'h500, 32'h55, 2'b10);
      tick();
      chk("invalid.rw", RegWriteW, 1'b0);
      chk("invalid.valid", ValidW, 1'b0);
      chk("invalid.ret", InstRetW, 32'd4);
      chk("invalid.rd", RdW, 5'd14);

      // counter wrap on the CNT_W=4 instance
      #1 rst = 1'b0;
      #1;
      model_reset();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         set_in(1, 1, 5'(i), 0, 3'b010, 32'(i), 32'(i), 2'b00);
         tick();
         if (i == 14) chk("wrap.pre", cnt4, 4'hF);
      end
      chk("wrap.w4", cnt4, 4'h0);
      chk("wrap.w32", InstRetW, 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
